// File: rtl/inj_sched_pkg.sv
// Shared types and width helpers for the injection scheduler.
package inj_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Bits needed to hold values 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int DEF_NUM_PORTS  = 4;
  localparam int DEF_TEST_CASES = 5;
  localparam int DEF_CREDIT_MAX = 4;
  localparam int DEF_INJ_PERIOD = 1;
  localparam int DEF_CNT_W      = cnt_width(DEF_TEST_CASES);
  localparam int DEF_CRD_W      = cnt_width(DEF_CREDIT_MAX);
  localparam int DEF_TMR_W      = cnt_width(DEF_INJ_PERIOD - 1);

endpackage

// File: rtl/inj_port_ctrl.sv
// One injection port: credit counter, rate timer, issue count, error flag.
// Stall flag output exists only when INJ_SCHED_STATS_EN is defined.
module inj_port_ctrl #(
  parameter int TEST_CASES = 5,
  parameter int CREDIT_MAX = 4,
  parameter int INJ_PERIOD = 1,
  parameter int CNT_W      = 3,
  parameter int CRD_W      = 3,
  parameter int TMR_W      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_run,
  input  logic             i_clear,
  input  logic             i_credit_ret,
  output logic             o_en,
  output logic             o_cnt_done,
  output logic             o_credit_full,
  output logic             o_err,
`ifdef INJ_SCHED_STATS_EN
  output logic             o_stall,
`endif
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] LP_TC     = CNT_W'(TEST_CASES);
  localparam logic [CRD_W-1:0] LP_CRD    = CRD_W'(CREDIT_MAX);
  localparam logic [TMR_W-1:0] LP_RELOAD = TMR_W'(INJ_PERIOD - 1);

  logic [CNT_W-1:0] r_count;
  logic [CRD_W-1:0] r_credit;
  logic [TMR_W-1:0] r_timer;
  logic             r_err;
  logic             w_en;

  assign o_cnt_done    = (r_count >= LP_TC);
  assign o_credit_full = (r_credit == LP_CRD);
  assign w_en          = i_run & ~o_cnt_done & (r_credit != '0) & (r_timer == '0);
  assign o_en          = w_en;
  assign o_err         = r_err;
  assign o_count       = r_count;
`ifdef INJ_SCHED_STATS_EN
  assign o_stall       = ~o_cnt_done & (r_timer == '0) & (r_credit == '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_credit <= LP_CRD;
      r_timer  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (i_clear) begin
        r_count <= '0;
        r_timer <= '0;
      end else if (w_en) begin
        r_count <= r_count + 1'b1;
        r_timer <= LP_RELOAD;
      end else if (r_timer != '0) begin
        r_timer <= r_timer - 1'b1;
      end
      // An issue and a return on the same edge cancel out.
      if (w_en && !i_credit_ret) begin
        r_credit <= r_credit - 1'b1;
      end else if (!w_en && i_credit_ret) begin
        if (!o_credit_full) r_credit <= r_credit + 1'b1;
        else                r_err    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/injection_scheduler.sv
// Run sequencer for the test-vector input buffers: restart, credit/rate-gated
// injection, drain, done. Define INJ_SCHED_STATS_EN to add stall_cycles.
module injection_scheduler
  import inj_sched_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int TEST_CASES = DEF_TEST_CASES,
  parameter int CREDIT_MAX = DEF_CREDIT_MAX,
  parameter int INJ_PERIOD = DEF_INJ_PERIOD,
  localparam int CNT_W     = cnt_width(TEST_CASES),
  localparam int CRD_W     = cnt_width(CREDIT_MAX),
  localparam int TMR_W     = cnt_width(INJ_PERIOD - 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_PORTS-1:0]       credit_ret,
  output logic                       buf_rst,
  output logic [NUM_PORTS-1:0]       buf_en,
  output logic                       busy,
  output logic                       done,
  output logic                       credit_err,
  output state_t                     dbg_state,
`ifdef INJ_SCHED_STATS_EN
  output logic [31:0]                stall_cycles,
`endif
  output logic [NUM_PORTS*CNT_W-1:0] inj_count
);

  state_t               r_state;
  state_t               w_next;
  logic                 w_run;
  logic                 w_clear;
  logic [NUM_PORTS-1:0] w_cnt_done;
  logic [NUM_PORTS-1:0] w_crd_full;
  logic [NUM_PORTS-1:0] w_err;
`ifdef INJ_SCHED_STATS_EN
  logic [NUM_PORTS-1:0] w_stall;
  logic [31:0]          r_stall_cycles;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = INIT;
      INIT:    w_next = RUN;
      RUN:     if (&w_cnt_done) w_next = DRAIN;
      DRAIN:   if (&w_crd_full) w_next = DONE;
      DONE:    if (start) w_next = INIT;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    buf_rst = (r_state == INIT);
    w_clear = (r_state == INIT);
    w_run   = (r_state == RUN);
    busy    = (r_state == INIT) || (r_state == RUN) || (r_state == DRAIN);
    done    = (r_state == DONE);
  end

  assign credit_err = |w_err;
  assign dbg_state  = r_state;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    inj_port_ctrl #(
      .TEST_CASES (TEST_CASES),
      .CREDIT_MAX (CREDIT_MAX),
      .INJ_PERIOD (INJ_PERIOD),
      .CNT_W      (CNT_W),
      .CRD_W      (CRD_W),
      .TMR_W      (TMR_W)
    ) u_port (
      .clk           (clk),
      .rst           (rst),
      .i_run         (w_run),
      .i_clear       (w_clear),
      .i_credit_ret  (credit_ret[g]),
      .o_en          (buf_en[g]),
      .o_cnt_done    (w_cnt_done[g]),
      .o_credit_full (w_crd_full[g]),
      .o_err         (w_err[g]),
`ifdef INJ_SCHED_STATS_EN
      .o_stall       (w_stall[g]),
`endif
      .o_count       (inj_count[g*CNT_W +: CNT_W])
    );
  end

`ifdef INJ_SCHED_STATS_EN
  // Counts RUN cycles lost purely to missing credit; saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_stall_cycles <= '0;
    else if (r_state == INIT)        r_stall_cycles <= '0;
    else if (w_run && (|w_stall) && (r_stall_cycles != '1))
                                     r_stall_cycles <= r_stall_cycles + 1'b1;
  end
  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_injection_scheduler.sv
// Directed bench: default instance plus an INJ_PERIOD=3 instance.
module tb_injection_scheduler;
  import inj_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start3;
  logic [3:0]  credit_ret, credit_ret3;
  logic        buf_rst, busy, done, credit_err;
  logic        buf_rst3, busy3, done3, credit_err3;
  logic [3:0]  buf_en, buf_en3;
  logic [11:0] inj_count, inj_count3;
  state_t      dbg_state, dbg_state3;
`ifdef INJ_SCHED_STATS_EN
  logic [31:0] stall_cycles, stall_cycles3;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  injection_scheduler u_dut (
    .clk(clk), .rst(rst), .start(start), .credit_ret(credit_ret),
    .buf_rst(buf_rst), .buf_en(buf_en), .busy(busy), .done(done),
    .credit_err(credit_err), .dbg_state(dbg_state),
`ifdef INJ_SCHED_STATS_EN
    .stall_cycles(stall_cycles),
`endif
    .inj_count(inj_count)
  );

  injection_scheduler #(.INJ_PERIOD(3)) u_dut_p3 (
    .clk(clk), .rst(rst), .start(start3), .credit_ret(credit_ret3),
    .buf_rst(buf_rst3), .buf_en(buf_en3), .busy(busy3), .done(done3),
    .credit_err(credit_err3), .dbg_state(dbg_state3),
`ifdef INJ_SCHED_STATS_EN
    .stall_cycles(stall_cycles3),
`endif
    .inj_count(inj_count3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] h1, h2, exp_en;
    rst = 1'b1; start = 1'b0; start3 = 1'b0; credit_ret = '0; credit_ret3 = '0;
    repeat (2) @(negedge clk);
    chk("rst_buf_en", 32'(buf_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_buf_rst", 32'(buf_rst), 32'h0);
    chk("rst_err", 32'(credit_err), 32'h0);
    chk("rst_count", 32'(inj_count), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    step();

    // Run 1: exhaust credits, stall, then return credits and drain.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("a_buf_rst", 32'(buf_rst), 32'h1);
    chk("a_init_busy", 32'(busy), 32'h1);
    chk("a_init_en", 32'(buf_en), 32'h0);
    step();
    for (int c = 2; c <= 5; c++) begin
      chk($sformatf("a_en_c%0d", c), 32'(buf_en), 32'hf);
      step();
    end
    chk("a_en_c6", 32'(buf_en), 32'h0);
    chk("a_cnt4", 32'(inj_count), 32'({4{3'd4}}));
    repeat (10) step();
    chk("a_stall_state", 32'(dbg_state), 32'(RUN));
    chk("a_stall_en", 32'(buf_en), 32'h0);
    chk("a_stall_done", 32'(done), 32'h0);
`ifdef INJ_SCHED_STATS_EN
    chk("a_stall_cycles", stall_cycles, 32'd10);
`endif
    credit_ret = 4'hf;
    step();
    credit_ret = 4'h0;
    chk("a_en_extra", 32'(buf_en), 32'hf);
    step();
    chk("a_en_after", 32'(buf_en), 32'h0);
    chk("a_cnt5", 32'(inj_count), 32'({4{3'd5}}));
    credit_ret = 4'hf;
    repeat (4) step();
    credit_ret = 4'h0;
    chk("a_drain_state", 32'(dbg_state), 32'(DRAIN));
    chk("a_drain_done", 32'(done), 32'h0);
    chk("a_drain_busy", 32'(busy), 32'h1);
    step();
    chk("a_done", 32'(done), 32'h1);
    chk("a_done_busy", 32'(busy), 32'h0);
    chk("a_done_err", 32'(credit_err), 32'h0);

    // Run 2: issue and return on port 1 in the same cycle.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b_buf_rst", 32'(buf_rst), 32'h1);
    step();
    chk("b_en1", 32'(buf_en), 32'hf);
    chk("b_cnt0", 32'(inj_count), 32'h0);
    credit_ret = 4'b0010;
    step();
    credit_ret = 4'h0;
    chk("b_en2", 32'(buf_en), 32'hf);
    chk("b_cnt1", 32'(inj_count), 32'({4{3'd1}}));
    step();
    step();
    step();
    chk("b_en5", 32'(buf_en), 32'b0010);
    step();
    chk("b_en6", 32'(buf_en), 32'h0);
    chk("b_cnt", 32'(inj_count), 32'({3'd4, 3'd4, 3'd5, 3'd4}));
    chk("b_err", 32'(credit_err), 32'h0);
    chk("b_busy", 32'(busy), 32'h1);

    // Run 3: asynchronous abort while enables are active.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("c_buf_rst", 32'(buf_rst), 32'h1);
    step();
    chk("c_en1", 32'(buf_en), 32'hf);
    step();
    chk("c_cnt1", 32'(inj_count), 32'({4{3'd1}}));
    #2 rst = 1'b1;
    #1;
    chk("c_async_en", 32'(buf_en), 32'h0);
    chk("c_async_busy", 32'(busy), 32'h0);
    chk("c_async_state", 32'(dbg_state), 32'(IDLE));
    chk("c_async_cnt", 32'(inj_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Over-return on port 2 while its credit is already full.
    credit_ret = 4'b0100;
    step();
    credit_ret = 4'h0;
    chk("d_err_set", 32'(credit_err), 32'h1);
    repeat (3) step();
    chk("d_err_hold", 32'(credit_err), 32'h1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("d_buf_rst", 32'(buf_rst), 32'h1);
    chk("d_err_init", 32'(credit_err), 32'h1);
    step();
    chk("d_en1", 32'(buf_en), 32'hf);
    chk("d_cnt0", 32'(inj_count), 32'h0);
    step();
    chk("d_cnt1", 32'(inj_count), 32'({4{3'd1}}));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("d_err_clr", 32'(credit_err), 32'h0);
    step();

    // INJ_PERIOD=3 instance with credits echoed two cycles after issue.
    h1 = '0; h2 = '0;
    start3 = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 1) begin
        start3 = 1'b0;
        chk("p3_buf_rst", 32'(buf_rst3), 32'h1);
      end
      if (c >= 2 && c <= 16) begin
        exp_en = (c <= 14 && ((c - 2) % 3) == 0) ? 4'hf : 4'h0;
        chk($sformatf("p3_en_c%0d", c), 32'(buf_en3), 32'(exp_en));
      end
      if (c == 17) chk("p3_done17", 32'(done3), 32'h0);
      if (c == 18) chk("p3_done18", 32'(done3), 32'h1);
      credit_ret3 = h2;
      h2 = h1;
      h1 = buf_en3;
    end
    credit_ret3 = '0;
    chk("p3_cnt", 32'(inj_count3), 32'({4{3'd5}}));
    chk("p3_err", 32'(credit_err3), 32'h0);
    chk("p3_busy", 32'(busy3), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/injection_scheduler.md
Name: injection_scheduler

Overview:
- Sequences a bank of NUM_PORTS test-vector input buffers that inject flits into the flattened-butterfly network under test.
- Restarts the buffers, then gates each buffer's enable by per-port credit (downstream router buffer space) and a per-port injection-rate timer.
- Stops each port after TEST_CASES flits, waits for all credits to return, then reports done.

Parameters:
- NUM_PORTS, 4, number of input buffers/router injection ports controlled
- TEST_CASES, 5, flits injected per port per run (must match the buffers' TEST_CASES)
- CREDIT_MAX, 4, downstream buffer depth per port; reset value of each credit counter
- INJ_PERIOD, 1, minimum cycles between injections on one port (>=1; 1 = back-to-back)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a run; sampled in IDLE and DONE only
- credit_ret  in  NUM_PORTS  one-cycle pulse per port = one downstream slot freed
- buf_rst  out  1  synchronous reset to all input buffers (rewinds address to 0)
- buf_en  out  NUM_PORTS  enable to each input buffer; one flit per asserted cycle
- busy  out  1  high in INIT, RUN, DRAIN
- done  out  1  high in DONE
- credit_err  out  1  sticky: credit returned while counter already CREDIT_MAX
- inj_count  out  NUM_PORTS*CNT_W  flits issued per port, port i at [i*CNT_W +: CNT_W]; CNT_W = clog2(TEST_CASES+1)

Behaviour:
- Reset (async, any state): state=IDLE; credits=CREDIT_MAX; counts=0; timers=0; credit_err=0; buf_en=0, buf_rst=0, busy=0, done=0.
- FSM: IDLE -start-> INIT; INIT -> RUN (unconditional, 1 cycle); RUN -> DRAIN when every count==TEST_CASES; DRAIN -> DONE when every credit==CREDIT_MAX (minimum one DRAIN cycle); DONE -start-> INIT. start ignored in INIT/RUN/DRAIN.
- INIT: buf_rst=1 for exactly that cycle; counts and timers cleared; credits not touched (flits from a prior run may still be in flight only if DRAIN was skipped, which cannot occur).
- buf_en[i] = (state==RUN) & count[i]<TEST_CASES & credit[i]>0 & timer[i]==0; decoded from registers only, no input-to-output combinational path.
- On an edge with buf_en[i]=1: count[i]+1, credit[i]-1, timer[i]<=INJ_PERIOD-1. Else timer[i] decrements if nonzero.
- credit_ret[i] alone: credit[i]+1 if <CREDIT_MAX, else unchanged and credit_err<=1. Simultaneous buf_en[i] and credit_ret[i]: credit[i] unchanged, no error.
- credit_ret accepted in every state, including IDLE and DONE.
- Ports are independent; no arbitration between ports.
- Buffer data appears one cycle after buf_en (buffer latency); scheduler does not observe it.
- rst mid-run: immediate abort to IDLE; buffers are rewound by the next INIT.

Optional Feature:
- Macro INJ_SCHED_STATS_EN.
- Defined: extra output stall_cycles (32 bits), cleared in INIT, +1 on each RUN cycle where any port has count<TEST_CASES, timer==0, credit==0; saturates at all-ones; held in DRAIN/DONE.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package inj_sched_pkg: state enum (IDLE, INIT, RUN, DRAIN, DONE), width helper constants (CNT_W, credit width clog2(CREDIT_MAX+1), timer width).
- Sub-module inj_port_ctrl: one port's credit counter, rate timer, issue count, eligibility and error flag; generate-instantiated NUM_PORTS times; top holds FSM and reductions.

Test Plan:
- Defaults, credit_ret=0, start pulse at cycle 0: buf_rst high cycle 1; buf_en=4'b1111 cycles 2-5; low thereafter; each inj_count=4; FSM remains in RUN.
- Continue: one credit_ret pulse per port -> exactly one more buf_en per port; counts=5; then 4 more returns per port (5 total) -> done high once all credits=4; busy low.
- INJ_PERIOD=3, credits never exhausted (credit_ret echoed 2 cycles after buf_en): buf_en[0] high on cycles 2, 5, 8, 11, 14; 5 flits; then DRAIN -> DONE.
- Same-cycle buf_en[1] and credit_ret[1]: credit[1] unchanged; credit_err stays 0. Extra credit_ret[2] while credit=4 -> credit_err=1, persists until rst.
- rst asserted mid-RUN, asynchronously: buf_en=0 without a clock edge; state IDLE. Next start -> buf_rst pulse, counts restart from 0.
- With INJ_SCHED_STATS_EN, credit_ret=0 for 10 cycles after the first 4 flits: stall_cycles=10; without the macro, build succeeds with no stall_cycles port.
